uart_ram_bridge: RTL and testbench
==================================

UART_RAM_BRIDGE -- requirements
Module: uart_ram_bridge

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning memory word width; legal values 32 and 64.
REQ-002 SHALL have parameter NUM_RAM, default 2, meaning number of RAM channels; legal range 1..4 (channel 0 = IRAM, 1 = DRAM).
REQ-003 SHALL use one clock and a synchronous, active-high reset: clk_i  in  1  clock; rst_i  in  1  synchronous active-high reset.
REQ-004 SHALL have the following byte-stream ports:
- rx_data_i  in  8  UART receive byte.
- rx_vld_i  in  1  receive byte valid.
- rx_rdy_o  out  1  bridge accepts a receive byte.
- tx_data_o  out  8  UART transmit byte.
- tx_vld_o  out  1  transmit byte valid.
- tx_rdy_i  in  1  UART accepts a transmit byte.
REQ-005 SHALL have the following CPU control ports:
- cpu_fault_i  in  1  CPU fault level.
- cpu_rst_n_o  out  1  CPU held in reset when 0.
REQ-006 SHALL have the following memory ports:
- mem_sel_o  out  2  selected RAM channel.
- mem_addr_o  out  XLEN  byte address, word-aligned.
- mem_wr_en_o  out  1  write strobe.
- mem_wr_be_o  out  XLEN/8  byte enables.
- mem_wr_data_o  out  XLEN  write word.
- mem_rd_en_o  out  1  read strobe.
- mem_rd_data_i  in  XLEN  read word, valid exactly 1 cycle after mem_rd_en_o.

Function
REQ-007 A byte SHALL transfer on a cycle where both valid and ready are high, on both the rx and tx sides.
REQ-008 tx_vld_o SHALL stay high with tx_data_o stable until that byte transfers.
REQ-009 The FSM SHALL have these states: IDLE, CFG_WR, CFG_RD, SEL, DAT_WR, RD_REQ, RD_WAIT, RD_TX, CK_TX.
REQ-010 In IDLE, each received command byte SHALL act as follows:
- 0x2a: cpu_rst_n_o <= 0.
- 0x2b: cpu_rst_n_o <= 1.
- 0x2c: go to CFG_WR.
- 0x2d: go to CFG_RD.
- 0x2e: go to DAT_WR.
- 0x2f: go to RD_REQ.
- 0x30: go to SEL.
- Any other byte: ignored, stay in IDLE.
REQ-011 Commands 0x2c..0x30 SHALL force cpu_rst_n_o to 0.
REQ-012 CFG_WR SHALL accept 8 bytes, little-endian: addr[31:0] then size[31:0]. The upper address bits SHALL be zero-filled when XLEN=64. The FSM SHALL then return to IDLE.
REQ-013 CFG_RD SHALL transmit the same 8 bytes in the same order, then return to IDLE.
REQ-014 SEL SHALL accept 1 byte and latch byte[1:0] into mem_sel_o; a value >= NUM_RAM SHALL be clamped to NUM_RAM-1.
REQ-015 size SHALL be the byte count minus 1, so a transfer carries size+1 bytes; size=0 means 1 byte.
REQ-016 DAT_WR SHALL pack the byte at address A into lane A mod (XLEN/8) and set that lane's byte enable.
REQ-017 DAT_WR SHALL issue one mem_wr_en_o pulse when the top lane is filled or the last byte arrives, whichever comes first, then clear the byte enables.
REQ-018 An unaligned start address SHALL produce a partial first word; an unaligned end SHALL produce a partial last word.
REQ-019 The read path SHALL operate as follows:
- RD_REQ pulses mem_rd_en_o for one cycle at the word containing the current address.
- RD_WAIT captures mem_rd_data_i.
- RD_TX transmits bytes from lane (addr mod XLEN/8) upward, re-entering RD_REQ when crossing a word boundary, until size+1 bytes have been sent.
REQ-020 The address counter SHALL be XLEN bits and wrap modulo 2^XLEN; wrap-around SHALL NOT terminate the transfer.
REQ-021 mem_wr_en_o and mem_rd_en_o SHALL be 0 whenever cpu_rst_n_o=1; a transfer command forces cpu_rst_n_o to 0 first.
REQ-022 A rising edge of cpu_fault_i SHALL set a pending flag.
REQ-023 In IDLE with the tx side idle, a pending fault SHALL transmit 0xEF and clear the flag.
REQ-024 A fault edge that arrives during a transfer SHALL be held pending and sent after the transfer completes.
REQ-025 A fault edge on the same cycle as a command byte SHALL have the command processed first.
REQ-026 rx_rdy_o SHALL be 0 in RD_REQ, RD_WAIT, RD_TX, CFG_RD and CK_TX, and 1 otherwise.

Reset
REQ-027 rst_i SHALL act mid-operation on the next clock edge: it aborts any transfer and discards partially packed write words without issuing a write.
REQ-028 On rst_i the following SHALL hold:
- FSM = IDLE.
- cpu_rst_n_o = 0.
- tx_vld_o = 0, tx_data_o = 0x00, rx_rdy_o = 0.
- mem_wr_en_o = 0, mem_rd_en_o = 0, mem_wr_be_o = 0, mem_wr_data_o = 0, mem_addr_o = 0.
- mem_sel_o = 0.
- addr = 0, size = 0.
- Fault pending flag = 0, checksum = 0.
REQ-029 rx_rdy_o SHALL become 1 on the first cycle after rst_i deasserts.

Configuration
REQ-030 With UART_RAM_BRIDGE_CKSUM_EN defined:
- An 8-bit running checksum (XOR of all data bytes) SHALL be cleared at the start of each DATA_WR or DATA_RD.
- After the last data byte, CK_TX SHALL transmit the checksum byte, then the FSM returns to IDLE.
REQ-031 Without UART_RAM_BRIDGE_CKSUM_EN, CK_TX SHALL be unreachable and no trailing byte SHALL be sent.

Verification
REQ-032 Scenario: config round trip. Send 2c 00 10 00 00 03 00 00 00, then 2d -> tx 00 10 00 00 03 00 00 00.
REQ-033 Scenario: aligned write, XLEN=32. With addr=0x1000, size=3, send 2e 11 22 33 44 -> one write, addr 0x1000, be=0xF, data 0x44332211; cksum build additionally sends 0x44.
REQ-034 Scenario: unaligned write. With addr=0x1003, size=1, send 2e AA BB -> writes at 0x1000 be=0x8 data[31:24]=AA, then at 0x1004 be=0x1 data[7:0]=BB.
REQ-035 Scenario: read. With addr=0x1002, size=2, and memory at 0x1000=0x44332211, 0x1004=0x88776655, send 2f -> tx 33 44 55, with two mem_rd_en_o pulses.
REQ-036 Scenario: fault during read. Pulse cpu_fault_i mid-read -> the read bytes complete first, then 0xEF is sent.
REQ-037 Scenario: reset mid-write. Assert rst_i after 2 of 4 bytes -> no mem_wr_en_o pulse, and all outputs at their reset values next cycle.

Source files
------------

// File: rtl/uart_ram_bridge_if.sv
// UART byte stream and RAM bus bundle for uart_ram_bridge.
// Modports: master = bridge side, slave = UART/RAM side.
//
// Signals (named from the bridge's point of view):
//   rx_data_i/rx_vld_i/rx_rdy_o   receive byte handshake
//   tx_data_o/tx_vld_o/tx_rdy_i   transmit byte handshake
//   mem_sel_o                     RAM channel select
//   mem_addr_o                    word-aligned byte address
//   mem_wr_en_o/_be_o/_data_o     write strobe, byte enables, data
//   mem_rd_en_o/mem_rd_data_i     read strobe, data one cycle later
interface uart_ram_bridge_if #(
    parameter int XLEN = 32
);
    logic [7:0]        rx_data_i;
    logic              rx_vld_i;
    logic              rx_rdy_o;
    logic [7:0]        tx_data_o;
    logic              tx_vld_o;
    logic              tx_rdy_i;
    logic [1:0]        mem_sel_o;
    logic [XLEN-1:0]   mem_addr_o;
    logic              mem_wr_en_o;
    logic [XLEN/8-1:0] mem_wr_be_o;
    logic [XLEN-1:0]   mem_wr_data_o;
    logic              mem_rd_en_o;
    logic [XLEN-1:0]   mem_rd_data_i;

    modport master (
        input  rx_data_i, rx_vld_i, tx_rdy_i, mem_rd_data_i,
        output rx_rdy_o, tx_data_o, tx_vld_o,
        output mem_sel_o, mem_addr_o,
        output mem_wr_en_o, mem_wr_be_o, mem_wr_data_o,
        output mem_rd_en_o
    );

    modport slave (
        output rx_data_i, rx_vld_i, tx_rdy_i, mem_rd_data_i,
        input  rx_rdy_o, tx_data_o, tx_vld_o,
        input  mem_sel_o, mem_addr_o,
        input  mem_wr_en_o, mem_wr_be_o, mem_wr_data_o,
        input  mem_rd_en_o
    );
endinterface

// File: rtl/uart_ram_bridge.sv
// UART command bridge: loads/dumps CPU RAMs over a byte stream,
// controls CPU reset and reports CPU faults (0xEF).
//
// Ports:
//   clk_i        clock
//   rst_i        synchronous active-high reset
//   cpu_fault_i  CPU fault level (rising edge is reported)
//   cpu_rst_n_o  CPU held in reset when 0
//   bus          uart_ram_bridge_if.master (rx/tx bytes, RAM bus)
//
// Option: define UART_RAM_BRIDGE_CKSUM_EN to append an XOR
// checksum byte after every data write or read transfer.
module uart_ram_bridge #(
    parameter int XLEN    = 32,
    parameter int NUM_RAM = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic cpu_fault_i,
    output logic cpu_rst_n_o,
    uart_ram_bridge_if.master bus
);

    localparam int NB = XLEN / 8;
    localparam int LB = $clog2(NB);
    localparam logic [XLEN-1:0] ADDR_ONE = XLEN'(1);

`ifdef UART_RAM_BRIDGE_CKSUM_EN
    localparam bit CKSUM_EN = 1'b1;
`else
    localparam bit CKSUM_EN = 1'b0;
`endif

    typedef enum logic [3:0] {
        IDLE, CFG_WR, CFG_RD, SEL, DAT_WR,
        RD_REQ, RD_WAIT, RD_TX, CK_TX
    } state_t;

    state_t          state;
    logic            cpu_rst_n;
    logic            rdy_en;
    logic            tx_vld;
    logic [7:0]      tx_data;
    logic [1:0]      sel;
    logic [XLEN-1:0] addr;
    logic [31:0]     size;
    logic [XLEN-1:0] ptr;
    logic [31:0]     cnt;
    logic [2:0]      bidx;
    logic            wr_en;
    logic            rd_en;
    logic [NB-1:0]   wr_be;
    logic [XLEN-1:0] wr_data;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] rd_word;
    logic            fault_q;
    logic            fault_pend;
    logic [7:0]      cksum;

    logic            rx_rdy;
    logic            rx_fire;
    logic            tx_fire;
    logic            fault_edge;
    logic [7:0]      rx_b;
    logic [LB-1:0]   lane;
    logic [LB+2:0]   lane_sh;
    logic [NB-1:0]   lane_oh;
    logic            top;
    logic            last;
    logic [XLEN-1:0] ptr_nxt;
    logic [4:0]      cfg_sh;
    logic [7:0]      cfg_byte;
    logic [7:0]      rd_byte;
    logic [1:0]      sel_cl;

    always_comb begin
        rx_rdy = 1'b0;
        if (rdy_en) begin
            rx_rdy = (state == IDLE) || (state == CFG_WR) ||
                     (state == SEL)  || (state == DAT_WR);
        end
    end

    assign rx_fire    = bus.rx_vld_i & rx_rdy;
    assign tx_fire    = tx_vld & bus.tx_rdy_i;
    assign fault_edge = cpu_fault_i & ~fault_q;
    assign rx_b       = bus.rx_data_i;
    assign lane       = ptr[LB-1:0];
    assign lane_sh    = {lane, 3'b000};
    assign lane_oh    = NB'(1) << lane;
    assign top        = &lane;
    assign last       = (cnt == size);
    assign ptr_nxt    = ptr + ADDR_ONE;
    assign cfg_sh     = {bidx[1:0], 3'b000};
    assign cfg_byte   = bidx[2] ? size[cfg_sh +: 8] : addr[cfg_sh +: 8];
    assign rd_byte    = rd_word[lane_sh +: 8];

    // Channel numbers beyond the populated RAMs map to the last one.
    always_comb begin
        sel_cl = rx_b[1:0];
        if (int'(rx_b[1:0]) >= NUM_RAM) begin
            sel_cl = 2'(NUM_RAM - 1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            cpu_rst_n  <= 1'b0;
            rdy_en     <= 1'b0;
            tx_vld     <= 1'b0;
            tx_data    <= 8'h00;
            sel        <= 2'd0;
            addr       <= '0;
            size       <= '0;
            ptr        <= '0;
            cnt        <= '0;
            bidx       <= '0;
            wr_en      <= 1'b0;
            rd_en      <= 1'b0;
            wr_be      <= '0;
            wr_data    <= '0;
            mem_addr   <= '0;
            rd_word    <= '0;
            fault_q    <= 1'b0;
            fault_pend <= 1'b0;
            cksum      <= 8'h00;
        end else begin
            rdy_en  <= 1'b1;
            fault_q <= cpu_fault_i;
            rd_en   <= 1'b0;
            if (fault_edge) fault_pend <= 1'b1;
            if (tx_fire) tx_vld <= 1'b0;
            // Byte enables live only for the write pulse cycle.
            if (wr_en) begin
                wr_en <= 1'b0;
                wr_be <= '0;
            end

            case (state)
                IDLE: begin
                    if (rx_fire) begin
                        case (rx_b)
                            8'h2a: cpu_rst_n <= 1'b0;
                            8'h2b: cpu_rst_n <= 1'b1;
                            8'h2c: begin
                                cpu_rst_n <= 1'b0;
                                bidx      <= '0;
                                state     <= CFG_WR;
                            end
                            8'h2d: begin
                                cpu_rst_n <= 1'b0;
                                bidx      <= '0;
                                state     <= CFG_RD;
                            end
                            8'h2e: begin
                                cpu_rst_n <= 1'b0;
                                ptr       <= addr;
                                cnt       <= '0;
                                cksum     <= 8'h00;
                                wr_be     <= '0;
                                state     <= DAT_WR;
                            end
                            8'h2f: begin
                                cpu_rst_n <= 1'b0;
                                ptr       <= addr;
                                cnt       <= '0;
                                cksum     <= 8'h00;
                                rd_en     <= 1'b1;
                                mem_addr  <= {addr[XLEN-1:LB], {LB{1'b0}}};
                                state     <= RD_REQ;
                            end
                            8'h30: begin
                                cpu_rst_n <= 1'b0;
                                state     <= SEL;
                            end
                            default: ;
                        endcase
                    end else if (fault_pend && !tx_vld) begin
                        tx_data    <= 8'hEF;
                        tx_vld     <= 1'b1;
                        fault_pend <= fault_edge;
                    end
                end

                CFG_WR: begin
                    if (rx_fire) begin
                        if (bidx[2]) size[cfg_sh +: 8] <= rx_b;
                        else         addr[cfg_sh +: 8] <= rx_b;
                        bidx <= bidx + 3'd1;
                        if (bidx == 3'd7) state <= IDLE;
                    end
                end

                CFG_RD: begin
                    if (!tx_vld) begin
                        tx_data <= cfg_byte;
                        tx_vld  <= 1'b1;
                        bidx    <= bidx + 3'd1;
                        if (bidx == 3'd7) state <= IDLE;
                    end
                end

                SEL: begin
                    if (rx_fire) begin
                        sel   <= sel_cl;
                        state <= IDLE;
                    end
                end

                DAT_WR: begin
                    if (rx_fire) begin
                        // A byte right after a write pulse opens a new word.
                        wr_be <= (wr_en ? '0 : wr_be) | lane_oh;
                        wr_data[lane_sh +: 8] <= rx_b;
                        cksum <= cksum ^ rx_b;
                        ptr   <= ptr_nxt;
                        cnt   <= cnt + 32'd1;
                        if (top || last) begin
                            wr_en    <= 1'b1;
                            mem_addr <= {ptr[XLEN-1:LB], {LB{1'b0}}};
                        end
                        if (last) state <= CKSUM_EN ? CK_TX : IDLE;
                    end
                end

                RD_REQ: state <= RD_WAIT;

                RD_WAIT: begin
                    rd_word <= bus.mem_rd_data_i;
                    state   <= RD_TX;
                end

                RD_TX: begin
                    if (!tx_vld) begin
                        tx_data <= rd_byte;
                        tx_vld  <= 1'b1;
                        cksum   <= cksum ^ rd_byte;
                        ptr     <= ptr_nxt;
                        cnt     <= cnt + 32'd1;
                        if (last) begin
                            state <= CKSUM_EN ? CK_TX : IDLE;
                        end else if (top) begin
                            rd_en    <= 1'b1;
                            mem_addr <= {ptr_nxt[XLEN-1:LB], {LB{1'b0}}};
                            state    <= RD_REQ;
                        end
                    end
                end

                CK_TX: begin
                    if (!tx_vld) begin
                        tx_data <= cksum;
                        tx_vld  <= 1'b1;
                        state   <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign cpu_rst_n_o       = cpu_rst_n;
    assign bus.rx_rdy_o      = rx_rdy;
    assign bus.tx_data_o     = tx_data;
    assign bus.tx_vld_o      = tx_vld;
    assign bus.mem_sel_o     = sel;
    assign bus.mem_addr_o    = mem_addr;
    assign bus.mem_wr_en_o   = wr_en;
    assign bus.mem_wr_be_o   = wr_be;
    assign bus.mem_wr_data_o = wr_data;
    assign bus.mem_rd_en_o   = rd_en;

endmodule

// File: tb/tb_uart_ram_bridge.sv
// Scoreboard bench for uart_ram_bridge (XLEN=32, NUM_RAM=2).
// Stimulus pushes expected tx bytes / writes; a monitor pops them.
module tb_uart_ram_bridge;

    typedef struct {
        logic [31:0] a;
        logic [3:0]  be;
        logic [31:0] d;
    } wr_t;

    logic clk = 1'b0;
    logic rst_i = 1'b1;
    logic cpu_fault_i = 1'b0;
    logic cpu_rst_n_o;

    uart_ram_bridge_if #(.XLEN(32)) bus ();

    uart_ram_bridge #(.XLEN(32), .NUM_RAM(2)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .cpu_fault_i (cpu_fault_i),
        .cpu_rst_n_o (cpu_rst_n_o),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    int cmp = 0;
    int mism = 0;
    int rd_pulses = 0;
    logic [7:0] exp_tx[$];
    wr_t exp_wr[$];
    logic [31:0] mem [logic [31:0]];

    logic       hold_v = 1'b0;
    logic [7:0] hold_d = 8'h00;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        cmp++;
        if (act !== exp) begin
            mism++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] bmask(input logic [3:0] be);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{be[i]}};
        return m;
    endfunction

    task automatic push_ck(input logic [7:0] v);
`ifdef UART_RAM_BRIDGE_CKSUM_EN
        exp_tx.push_back(v);
`else
        if (v === 8'hxx) exp_tx.push_back(v);
`endif
    endtask

    task automatic push_wr(input logic [31:0] a, input logic [3:0] be,
                           input logic [31:0] d);
        wr_t w;
        w.a = a;
        w.be = be;
        w.d = d;
        exp_wr.push_back(w);
    endtask

    // RAM model: data valid one cycle after the read strobe.
    always @(posedge clk) begin
        if (bus.mem_rd_en_o) begin
            bus.mem_rd_data_i <= mem.exists(bus.mem_addr_o) ?
                                 mem[bus.mem_addr_o] : 32'hDEADBEEF;
        end
    end

    initial begin
        int k = 0;
        bus.tx_rdy_i = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            k++;
            bus.tx_rdy_i = (k % 5 != 3);
        end
    end

    // Monitor: compares every DUT output event against the scoreboard.
    always @(negedge clk) begin
        if (!rst_i) begin
            if (hold_v) begin
                chk("tx_hold", {23'd0, bus.tx_vld_o, bus.tx_data_o},
                    {23'd0, 1'b1, hold_d});
            end
            if (bus.tx_vld_o && bus.tx_rdy_i) begin
                if (exp_tx.size() == 0) begin
                    cmp++;
                    mism++;
                    $display("FAIL tx_unexp: got %h want none",
                             bus.tx_data_o);
                end else begin
                    chk("tx_byte", {24'd0, bus.tx_data_o},
                        {24'd0, exp_tx.pop_front()});
                end
            end
            if (bus.mem_wr_en_o) begin
                if (exp_wr.size() == 0) begin
                    cmp++;
                    mism++;
                    $display("FAIL wr_unexp: got addr %h want none",
                             bus.mem_addr_o);
                end else begin
                    wr_t w;
                    w = exp_wr.pop_front();
                    chk("wr_addr", bus.mem_addr_o, w.a);
                    chk("wr_be", {28'd0, bus.mem_wr_be_o}, {28'd0, w.be});
                    chk("wr_data", bus.mem_wr_data_o & bmask(w.be),
                        w.d & bmask(w.be));
                end
            end
            if (bus.mem_rd_en_o) rd_pulses++;
            if (bus.mem_wr_en_o || bus.mem_rd_en_o) begin
                chk("strobe_cpu_rst", {31'd0, cpu_rst_n_o}, 32'd0);
            end
        end
        hold_v = !rst_i && bus.tx_vld_o && !bus.tx_rdy_i;
        hold_d = bus.tx_data_o;
    end

    task automatic send(input logic [7:0] b, input bit flt = 1'b0);
        int n = 0;
        @(negedge clk);
        bus.rx_data_i = b;
        bus.rx_vld_i = 1'b1;
        while (!bus.rx_rdy_o && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            cmp++;
            mism++;
            $display("FAIL rx_timeout: got no ready want ready");
            bus.rx_vld_i = 1'b0;
            return;
        end
        if (flt) cpu_fault_i = 1'b1;
        @(posedge clk);
        #1;
        bus.rx_vld_i = 1'b0;
        cpu_fault_i = 1'b0;
    endtask

    task automatic cfg(input logic [31:0] a, input logic [31:0] s);
        send(8'h2c);
        for (int i = 0; i < 4; i++) send(a[8*i +: 8]);
        for (int i = 0; i < 4; i++) send(s[8*i +: 8]);
    endtask

    task automatic push_cfg(input logic [31:0] a, input logic [31:0] s);
        for (int i = 0; i < 4; i++) exp_tx.push_back(a[8*i +: 8]);
        for (int i = 0; i < 4; i++) exp_tx.push_back(s[8*i +: 8]);
    endtask

    task automatic drain(input string nm);
        int n = 0;
        repeat (2) @(negedge clk);
        while ((exp_tx.size() != 0 || exp_wr.size() != 0 ||
                bus.tx_vld_o) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        cmp++;
        if (n >= 3000) begin
            mism++;
            $display("FAIL %s_drain: got %0d tx %0d wr left want 0",
                     nm, exp_tx.size(), exp_wr.size());
            exp_tx.delete();
            exp_wr.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int r0;
        bus.rx_data_i = 8'h00;
        bus.rx_vld_i = 1'b0;
        mem[32'h1000] = 32'h44332211;
        mem[32'h1004] = 32'h88776655;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_cpu_rst_n", {31'd0, cpu_rst_n_o}, 32'd0);
        chk("rst_rx_rdy", {31'd0, bus.rx_rdy_o}, 32'd0);
        chk("rst_tx_vld", {31'd0, bus.tx_vld_o}, 32'd0);
        chk("rst_wr_be", {28'd0, bus.mem_wr_be_o}, 32'd0);
        rst_i = 1'b0;
        @(posedge clk);
        #1;
        chk("rx_rdy_after_rst", {31'd0, bus.rx_rdy_o}, 32'd1);

        // CPU reset control
        send(8'h2b);
        chk("cpu_rel", {31'd0, cpu_rst_n_o}, 32'd1);
        send(8'h2a);
        chk("cpu_hold", {31'd0, cpu_rst_n_o}, 32'd0);
        send(8'h55);
        chk("ignored_cmd", {31'd0, bus.rx_rdy_o}, 32'd1);
        send(8'h2b);

        // Config round trip
        send(8'h2c);
        chk("cfg_forces_rst", {31'd0, cpu_rst_n_o}, 32'd0);
        for (int i = 0; i < 8; i++) send(i == 1 ? 8'h10 : (i == 4 ? 8'h03 : 8'h00));
        push_cfg(32'h1000, 32'd3);
        send(8'h2d);
        drain("cfg_rt");

        // Aligned write
        push_wr(32'h1000, 4'hF, 32'h44332211);
        push_ck(8'h44);
        send(8'h2e);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44);
        drain("wr_aligned");

        // Unaligned write
        cfg(32'h1003, 32'd1);
        push_wr(32'h1000, 4'h8, 32'hAA000000);
        push_wr(32'h1004, 4'h1, 32'h000000BB);
        push_ck(8'h11);
        send(8'h2e);
        send(8'hAA); send(8'hBB);
        drain("wr_unaligned");

        // Unaligned read across a word boundary
        cfg(32'h1002, 32'd2);
        r0 = rd_pulses;
        exp_tx.push_back(8'h33);
        exp_tx.push_back(8'h44);
        exp_tx.push_back(8'h55);
        push_ck(8'h22);
        send(8'h2f);
        drain("rd");
        chk("rd_pulses", 32'(rd_pulses - r0), 32'd2);

        // Fault while idle
        exp_tx.push_back(8'hEF);
        @(negedge clk);
        cpu_fault_i = 1'b1;
        repeat (2) @(negedge clk);
        cpu_fault_i = 1'b0;
        drain("fault_idle");

        // Fault during an 8-byte read
        cfg(32'h1000, 32'd7);
        r0 = rd_pulses;
        for (int i = 1; i <= 8; i++) exp_tx.push_back(8'(i * 8'h11));
        push_ck(8'h88);
        exp_tx.push_back(8'hEF);
        send(8'h2f);
        repeat (3) @(negedge clk);
        cpu_fault_i = 1'b1;
        repeat (2) @(negedge clk);
        cpu_fault_i = 1'b0;
        drain("fault_rd");
        chk("rd_pulses8", 32'(rd_pulses - r0), 32'd2);

        // Address wrap-around does not end the transfer
        cfg(32'hFFFFFFFE, 32'd3);
        push_wr(32'hFFFFFFFC, 4'hC, 32'h02010000);
        push_wr(32'h00000000, 4'h3, 32'h00000403);
        push_ck(8'h04);
        send(8'h2e);
        send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        drain("wr_wrap");

        // Fault edge together with a command byte
        push_cfg(32'hFFFFFFFE, 32'd3);
        exp_tx.push_back(8'hEF);
        send(8'h2d, 1'b1);
        drain("fault_cmd");

        // Channel select clamping
        send(8'h30); send(8'h03);
        chk("sel_clamp", {30'd0, bus.mem_sel_o}, 32'd1);
        send(8'h30); send(8'h00);
        chk("sel_zero", {30'd0, bus.mem_sel_o}, 32'd0);
        send(8'h30); send(8'h01);
        chk("sel_one", {30'd0, bus.mem_sel_o}, 32'd1);

        // Reset in the middle of a write
        cfg(32'h2000, 32'd3);
        send(8'h2e);
        send(8'h11); send(8'h22);
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_cpu_rst_n", {31'd0, cpu_rst_n_o}, 32'd0);
        chk("mid_rx_rdy", {31'd0, bus.rx_rdy_o}, 32'd0);
        chk("mid_tx_vld", {31'd0, bus.tx_vld_o}, 32'd0);
        chk("mid_tx_data", {24'd0, bus.tx_data_o}, 32'd0);
        chk("mid_wr_en", {31'd0, bus.mem_wr_en_o}, 32'd0);
        chk("mid_rd_en", {31'd0, bus.mem_rd_en_o}, 32'd0);
        chk("mid_wr_be", {28'd0, bus.mem_wr_be_o}, 32'd0);
        chk("mid_wr_data", bus.mem_wr_data_o, 32'd0);
        chk("mid_addr", bus.mem_addr_o, 32'd0);
        chk("mid_sel", {30'd0, bus.mem_sel_o}, 32'd0);
        rst_i = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rx_rdy_rel", {31'd0, bus.rx_rdy_o}, 32'd1);
        push_cfg(32'd0, 32'd0);
        send(8'h2d);
        drain("cfg_after_rst");

        chk("tx_left", 32'(exp_tx.size()), 32'd0);
        chk("wr_left", 32'(exp_wr.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mism);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
